adder_nbit_digit_serial: RTL and testbench

- Multi-cycle digit-serial adder/subtractor. Processes DIGIT bits per clock over WIDTH/DIGIT cycles.
- Trades the latency of a full-width ripple chain for a DIGIT-bit carry path plus a registered carry.
- Adds carry-in, subtract mode, signed overflow and valid/ready handshakes on both sides.
- Sits between PIM operand buffers and result writeback as the area-lean arithmetic unit.

---
 rtl/adder_pkg.sv | 20 ++
 rtl/adder_nbit_digit_serial_if.sv | 26 ++
 rtl/adder_nbit_digit_serial_digit.sv | 39 +++
 rtl/adder_nbit_digit_serial.sv | 132 +++++++++++++
 tb/tb_adder_nbit_digit_serial.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    // Number of digits per operand; a zero DIGIT is rejected by the top.
    function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
        return (digit == 0) ? 1 : width / digit;
    endfunction

    // Digit counter width, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_nbit_digit_serial_if.sv
// Operand and result handshake bundle for the digit-serial adder.
interface adder_nbit_digit_serial_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, Sum, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, Sum, Cout, Ovf
    );
endinterface

// File: rtl/adder_nbit_digit_serial_digit.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_digit #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);
    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        adder_1bit u_bit (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

    assign cout     = c[W];
    assign c_msb_in = c[W-1];
endmodule

// File: rtl/adder_nbit_digit_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, registered carry,
// valid/ready handshake on operands and result.
module adder_nbit_digit_serial
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input logic                         clk,
    input logic                         rst_n,
    adder_nbit_digit_serial_if.slave    bus
);
    localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
    localparam int unsigned CW   = cnt_width(NDIG);

    if ((DIGIT < 1) || ((WIDTH % ((DIGIT == 0) ? 1 : DIGIT)) != 0)) begin : g_bad_cfg
        $error("adder_nbit_digit_serial: WIDTH must be a positive multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             in_ready_o;
    logic             out_valid_o;
    logic             accept;
    logic             last;
    logic [31:0]      base;
    logic [WIDTH-1:0] a_shift, b_shift;
    logic [DIGIT-1:0] dig_a, dig_b, dig_s;
    logic             dig_cout, dig_cmsb;

    localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});

    assign accept  = bus.in_valid && in_ready_o;
    assign last    = (cnt_q == CW'(NDIG - 1));
    assign base    = 32'(cnt_q) * DIGIT;
    assign a_shift = a_q >> base;
    assign b_shift = b_q >> base;
    assign dig_a   = a_shift[DIGIT-1:0];
    assign dig_b   = b_shift[DIGIT-1:0];

    adder_digit #(.W(DIGIT)) u_digit (
        .a       (dig_a),
        .b       (dig_b),
        .cin     (carry_q),
        .s       (dig_s),
        .cout    (dig_cout),
        .c_msb_in(dig_cmsb)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: a DONE handshake with a waiting bundle goes straight to BUSY
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid) state_d = BUSY;
            BUSY:    if (last) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = bus.in_valid ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: in_ready depends only on state and out_ready
    always_comb begin
        in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
        out_valid_o = (state_q == DONE);
    end

    // Datapath: latch operands on accept, then one digit per BUSY cycle.
    // Subtract mode is folded into the inverted B and the initial carry, so no mode flop is kept.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = bus.A;
            b_d     = bus.B ^ {WIDTH{bus.Sub}};
            carry_d = bus.Cin ^ bus.Sub;
            cnt_d   = '0;
        end else if (state_q == BUSY) begin
            sum_d   = (sum_q & ~(DMASK << base)) | (WIDTH'(dig_s) << base);
            carry_d = dig_cout;
            cnt_d   = last ? '0 : cnt_q + CW'(1);
            if (last) begin
                cout_d = dig_cout;
                ovf_d  = dig_cmsb ^ dig_cout;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_o;
    assign bus.out_valid = out_valid_o;
    assign bus.Sum       = sum_q;
    assign bus.Cout      = cout_q;
    assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_adder_nbit_digit_serial.sv
// Bench for the digit-serial adder: three 8-bit instances (DIGIT 2, 8, 1)
// checked against an integer-arithmetic reference model.
module tb_adder_nbit_digit_serial;
    localparam int unsigned W    = 8;
    localparam int unsigned NDUT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic         in_valid_v  [NDUT];
    logic         out_ready_v [NDUT];
    logic         cin_v       [NDUT];
    logic         sub_v       [NDUT];
    logic [W-1:0] a_v         [NDUT];
    logic [W-1:0] b_v         [NDUT];

    logic         in_ready_w  [NDUT];
    logic         out_valid_w [NDUT];
    logic [W-1:0] sum_w       [NDUT];
    logic         cout_w      [NDUT];
    logic         ovf_w       [NDUT];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned DG = (g == 0) ? 2 : ((g == 1) ? 8 : 1);
        adder_nbit_digit_serial_if #(.WIDTH(W)) u_if ();
        assign u_if.in_valid  = in_valid_v[g];
        assign u_if.out_ready = out_ready_v[g];
        assign u_if.A         = a_v[g];
        assign u_if.B         = b_v[g];
        assign u_if.Cin       = cin_v[g];
        assign u_if.Sub       = sub_v[g];
        assign in_ready_w[g]  = u_if.in_ready;
        assign out_valid_w[g] = u_if.out_valid;
        assign sum_w[g]       = u_if.Sum;
        assign cout_w[g]      = u_if.Cout;
        assign ovf_w[g]       = u_if.Ovf;
        adder_nbit_digit_serial #(.WIDTH(W), .DIGIT(DG)) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (u_if.slave)
        );
    end

    function automatic int lat_of(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    // Reference: {Ovf, Cout, Sum} from plain signed/unsigned integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
        int ua, ub, sa, sb, u, s;
        logic co, ov;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!sub) begin
            u  = ua + ub + int'(cin);
            s  = sa + sb + int'(cin);
            co = (u > 255);
        end else begin
            u  = ua - ub - int'(cin);
            s  = sa - sb - int'(cin);
            co = (u >= 0);
        end
        ov = (s > 127) || (s < -128);
        return {ov, co, u[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int d, output int edges);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!out_valid_w[d] && edges < 50);
    endtask

    task automatic chk_result(input int d, input string tag, input logic [9:0] e);
        chk({tag, ".sum"},  32'(sum_w[d]),  32'(e[7:0]));
        chk({tag, ".cout"}, 32'(cout_w[d]), 32'(e[8]));
        chk({tag, ".ovf"},  32'(ovf_w[d]),  32'(e[9]));
    endtask

    task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub, input string tag);
        logic [9:0] e;
        int edges;
        e = model(a, b, cin, sub);
        a_v[d] = a; b_v[d] = b; cin_v[d] = cin; sub_v[d] = sub;
        in_valid_v[d] = 1'b1; out_ready_v[d] = 1'b0;
        chk({tag, ".in_ready"}, 32'(in_ready_w[d]), 1);
        @(posedge clk); #1;
        in_valid_v[d] = 1'b0;
        wait_valid(d, edges);
        chk({tag, ".latency"}, edges, lat_of(d));
        chk_result(d, tag, e);
        out_ready_v[d] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[d] = 1'b0;
        chk({tag, ".valid_drop"}, 32'(out_valid_w[d]), 0);
        chk({tag, ".idle_ready"}, 32'(in_ready_w[d]), 1);
    endtask

    initial begin
        logic [9:0] e;
        logic [7:0] ba [3];
        logic [7:0] bb [3];
        logic       bc [3];
        logic       bs [3];
        logic [7:0] ra, rb;
        logic       rc, rs;
        int edges;

        for (int i = 0; i < NDUT; i++) begin
            in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b0;
            a_v[i] = '0; b_v[i] = '0; cin_v[i] = 1'b0; sub_v[i] = 1'b0;
        end

        // Reset values on every instance
        #12;
        for (int i = 0; i < NDUT; i++) begin
            chk("rst.in_ready",  32'(in_ready_w[i]),  1);
            chk("rst.out_valid", 32'(out_valid_w[i]), 0);
            chk("rst.sum",       32'(sum_w[i]),       0);
            chk("rst.cout",      32'(cout_w[i]),      0);
            chk("rst.ovf",       32'(ovf_w[i]),       0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, DIGIT=2
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, "ff_plus_1");
        run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, "5_minus_7");
        run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, "80_minus_1");
        run_op(0, 8'h7F, 8'h00, 1'b1, 1'b0, "7f_plus_cin");
        run_op(0, 8'h00, 8'h00, 1'b1, 1'b1, "0_minus_borrow");

        // Backpressure: result held for 5 cycles, then exactly one handshake
        e = model(8'h3C, 8'h5A, 1'b1, 1'b0);
        a_v[0] = 8'h3C; b_v[0] = 8'h5A; cin_v[0] = 1'b1; sub_v[0] = 1'b0;
        in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        wait_valid(0, edges);
        chk("bp.latency", edges, 4);
        for (int i = 0; i < 5; i++) begin
            chk("bp.out_valid", 32'(out_valid_w[0]), 1);
            chk("bp.in_ready",  32'(in_ready_w[0]),  0);
            chk_result(0, "bp.hold", e);
            @(posedge clk); #1;
        end
        out_ready_v[0] = 1'b1;
        #1;
        chk("bp.ready_in_done", 32'(in_ready_w[0]), 1);
        @(posedge clk); #1;
        out_ready_v[0] = 1'b0;
        chk("bp.valid_drop", 32'(out_valid_w[0]), 0);
        @(posedge clk); #1;
        chk("bp.single_hs", 32'(out_valid_w[0]), 0);
        chk_result(0, "bp.kept", e);

        // Back-to-back: three queued bundles with in_valid/out_ready held high
        ba = '{8'h11, 8'hC8, 8'h80};
        bb = '{8'h22, 8'h39, 8'h7F};
        bc = '{1'b0, 1'b1, 1'b0};
        bs = '{1'b0, 1'b1, 1'b1};
        a_v[0] = ba[0]; b_v[0] = bb[0]; cin_v[0] = bc[0]; sub_v[0] = bs[0];
        in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                a_v[0] = ba[i+1]; b_v[0] = bb[i+1]; cin_v[0] = bc[i+1]; sub_v[0] = bs[i+1];
            end else begin
                in_valid_v[0] = 1'b0;
            end
            edges = 0;
            do begin
                @(posedge clk); #1;
                edges++;
                if (!out_valid_w[0]) chk("b2b.busy_ready", 32'(in_ready_w[0]), 0);
            end while (!out_valid_w[0] && edges < 50);
            chk("b2b.latency", edges, 4);
            chk("b2b.done_ready", 32'(in_ready_w[0]), 1);
            chk_result(0, "b2b", model(ba[i], bb[i], bc[i], bs[i]));
            @(posedge clk); #1;
        end
        out_ready_v[0] = 1'b0;
        chk("b2b.end_valid", 32'(out_valid_w[0]), 0);
        chk("b2b.end_ready", 32'(in_ready_w[0]), 1);

        // Reset while busy at digit 1
        a_v[0] = 8'hAA; b_v[0] = 8'h55; cin_v[0] = 1'b0; sub_v[0] = 1'b0;
        in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", 32'(out_valid_w[0]), 0);
        chk("midrst.sum",       32'(sum_w[0]),       0);
        chk("midrst.in_ready",  32'(in_ready_w[0]),  1);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("midrst.no_result", 32'(out_valid_w[0]), 0);
        end
        run_op(0, 8'h12, 8'h34, 1'b0, 1'b0, "after_rst");

        // Random sweep on all three digit sizes
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 12; i++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rc = 1'($urandom);
                rs = 1'($urandom);
                run_op(d, ra, rb, rc, rs, $sformatf("rnd_d%0d_%0d", d, i));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
